bcd_updown_timer: RTL

- Parametrised successor of the lab4 up/down stopwatch: an N-digit BCD up/down timer with prepare countdown, pause/resume, terminal detection, LED bar and multiplexed 7-segment driver.
- Runs entirely in the `clk` domain. Internal tick and scan strobes are clock enables; no derived clocks.
- Sits behind the debounce/one_pulse front end. All command inputs are single-cycle pulses synchronous to `clk`.

---
 rtl/bcd_updown_timer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_updown_timer.sv
// N-digit BCD up/down timer with a prepare countdown, pause/resume,
// terminal detection, an LED bar and a multiplexed 7-segment driver.
// Everything runs on clk; the tick and scan strobes are clock enables.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | count preset from dir, waiting for start
// PREP   | prepare countdown of PREP_TICKS ticks, LED bar blinking
// RUN    | counting one BCD step per tick
// PAUSE  | count frozen, waiting for resume or stop
// RESULT | count frozen, LED bar blinks four phases then stays lit
module bcd_updown_timer #(
   parameter int DIGITS      = 3,
   parameter int TICK_DIV    = 1000000,
   parameter int SCAN_DIV    = 100000,
   parameter int PREP_TICKS  = 300,
   parameter int BLINK_TICKS = 50
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_p,
   input  logic                  stop_p,
   input  logic                  pause_p,
   input  logic                  dir_p,
   output logic [DIGITS:0]       DIGIT,
   output logic [6:0]            DISPLAY,
   output logic [9:0]            led,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [2:0]            state_o,
   output logic                  done
);

   localparam int CW  = 4*DIGITS;
   localparam int TW  = $clog2(TICK_DIV);
   localparam int SW  = $clog2(SCAN_DIV);
   localparam int PW  = $clog2(PREP_TICKS+1);
   localparam int BW  = $clog2(BLINK_TICKS+1);
   localparam int PSW = $clog2(DIGITS+1);

   localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV-1);
   localparam logic [SW-1:0]  SCAN_LAST  = SW'(SCAN_DIV-1);
   localparam logic [PW-1:0]  PREP_LAST  = PW'(PREP_TICKS-1);
   localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_TICKS-1);
   localparam logic [PSW-1:0] MODE_POS   = PSW'(DIGITS);
   localparam logic [CW-1:0]  ALL9       = {DIGITS{4'h9}};

   localparam logic [6:0] SEG_P     = 7'h0C;
   localparam logic [6:0] SEG_UP    = 7'h5C;
   localparam logic [6:0] SEG_DN    = 7'h63;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PREP   = 3'd1,
      S_RUN    = 3'd2,
      S_PAUSE  = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [TW-1:0]    tick_cnt;
   logic [SW-1:0]    scan_cnt;
   logic             tick, scan;
   logic [PW-1:0]    prep_cnt;
   logic [BW-1:0]    blink_cnt;
   logic             blink_on;
   logic [1:0]       blink_flips;
   logic             dir;
   logic [CW-1:0]    count;
   logic [PSW-1:0]   scan_pos;
   logic             at_term, enter_result;
   logic [3:0]       cur_digit;
   logic [9:0]       led_d;
   logic [6:0]       seg_d;
   logic [DIGITS:0]  digit_d;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // one BCD step with ripple carry (up) or borrow (down) across all digits
   function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic down);
      logic [CW-1:0] r;
      logic          c;
      logic [3:0]    d;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (c) begin
            if (down) begin
               if (d == 4'd0) d = 4'd9;
               else begin d = d - 4'd1; c = 1'b0; end
            end else begin
               if (d == 4'd9) d = 4'd0;
               else begin d = d + 4'd1; c = 1'b0; end
            end
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   assign tick         = (tick_cnt == TICK_LAST);
   assign scan         = (scan_cnt == SCAN_LAST);
   assign at_term      = dir ? (count == '0) : (count == ALL9);
   assign enter_result = (state_nxt == S_RESULT) && (state != S_RESULT);
   assign count_bcd    = count;
   assign state_o      = state;

   // free-running strobe dividers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         scan_cnt <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         scan_cnt <= scan ? '0 : scan_cnt + 1'b1;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic; stop beats terminal beats pause
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start_p) state_nxt = S_PREP;
         S_PREP:   if (tick && prep_cnt == PREP_LAST) state_nxt = S_RUN;
         S_RUN: begin
            if (stop_p)                state_nxt = S_RESULT;
            else if (tick && at_term)  state_nxt = S_RESULT;
            else if (pause_p)          state_nxt = S_PAUSE;
         end
         S_PAUSE: begin
            if (stop_p)       state_nxt = S_RESULT;
            else if (pause_p) state_nxt = S_RUN;
         end
         S_RESULT: if (start_p) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // count and direction; a tick sharing a cycle with stop is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         dir   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               count <= dir ? ALL9 : '0;
               if (dir_p && !start_p) dir <= ~dir;
            end
            S_RUN: if (!stop_p && tick && !at_term) count <= bcd_step(count, dir);
            default: ;
         endcase
      end
   end

   // prep tick counter and LED blink phase; after three flips in RESULT the bar stays lit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prep_cnt    <= '0;
         blink_cnt   <= '0;
         blink_on    <= 1'b0;
         blink_flips <= '0;
      end else begin
         if (state == S_IDLE)                    prep_cnt <= '0;
         else if (state == S_PREP && tick)       prep_cnt <= prep_cnt + 1'b1;

         if (state == S_IDLE || enter_result) begin
            blink_cnt   <= '0;
            blink_on    <= 1'b0;
            blink_flips <= '0;
         end else if (tick && (state == S_PREP || state == S_RESULT)) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               if (state == S_PREP) begin
                  blink_on <= ~blink_on;
               end else if (blink_flips != 2'd3) begin
                  blink_on    <= ~blink_on;
                  blink_flips <= blink_flips + 2'd1;
               end
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // scan position walks the count digits then the mode symbol
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    scan_pos <= '0;
      else if (scan) scan_pos <= (scan_pos == MODE_POS) ? '0 : scan_pos + 1'b1;
   end

   // output decode for LED bar, segments, anode select and done
   always_comb begin
      led_d     = 10'h3FF;
      seg_d     = SEG_BLANK;
      digit_d   = '1;
      cur_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++)
         if (scan_pos == PSW'(i)) cur_digit = count[4*i +: 4];
      for (int i = 0; i <= DIGITS; i++)
         digit_d[i] = (scan_pos != PSW'(i));
      case (state)
         S_IDLE:            led_d = 10'h3FF;
         S_PREP, S_RESULT:  led_d = blink_on ? 10'h3FF : 10'h000;
         S_RUN, S_PAUSE:    led_d = 10'd1 << count[CW-1 -: 4];
         default:           led_d = 10'h3FF;
      endcase
      if (scan_pos == MODE_POS) begin
         if (state == S_PREP) seg_d = SEG_P;
         else                 seg_d = dir ? SEG_DN : SEG_UP;
      end else begin
         case (state)
            S_IDLE:                    seg_d = SEG_DASH;
            S_PREP:                    seg_d = SEG_BLANK;
            S_RUN, S_PAUSE, S_RESULT:  seg_d = seg7(cur_digit);
            default:                   seg_d = SEG_BLANK;
         endcase
      end
   end

   // registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led     <= 10'h3FF;
         done    <= 1'b0;
         DIGIT   <= '1;
         DISPLAY <= SEG_BLANK;
      end else begin
         led     <= led_d;
         done    <= enter_result;
         DIGIT   <= digit_d;
         DISPLAY <= seg_d;
      end
   end

endmodule
